fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the instruction-fetch stage. Every cycle it decides whether fetch advances, freezes or redirects. It drives the fetch stage's FREEZE, no_new_fetch, taken_branch1, nextInstruction_address and fetchNull2 inputs from decode stalls, instruction-memory readiness, resolved branches, exceptions and halt/resume. It also holds a redirect that arrives while fetch cannot advance, and keeps saturating stall and redirect counters.

## Interface
- DELAY_SLOT, 1, 1 = architectural branch delay slot (branch redirect does not squash); 0 = squash on branch redirect
- EXC_VECTOR, 32'h0000_0080, exception handler fetch address
- CNT_W, 16, width of performance counters
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low
- IM_READY  in  1  instruction memory returns valid data this cycle
- stall_ID  in  1  decode cannot accept a new fetch pair
- br_valid  in  1  decode presents a resolved branch this cycle
- br_taken  in  1  resolved branch is taken (qualified by br_valid)
- br_target  in  32  taken-branch target
- exc_valid  in  1  exception redirect request
- halt  in  1  halt instruction retired
- resume  in  1  external restart from halt
- FREEZE  out  1  fetch pipeline register hold, memory not ready
- no_new_fetch  out  1  fetch pipeline register hold, decode stall or halt
- taken_branch1  out  1  redirect issued this cycle
- nextInstruction_address  out  32  redirect address (valid when taken_branch1)
- fetchNull2  out  1  squash the instruction latched this cycle
- stall_cnt  out  CNT_W  cycles with advance=0, saturating
- redirect_cnt  out  CNT_W  redirects issued, saturating

## Operation
- advance = !FREEZE && !no_new_fetch.
- FREEZE = !IM_READY.
- no_new_fetch = stall_ID || state==HALT.
- Redirect request: exc_valid (addr EXC_VECTOR) beats br_valid&&br_taken (addr br_target).
- States are RUN, PEND and HALT. Registered: pend_addr[31:0] and pend_exc.
- RUN:
  - Request with advance=1: issue now (taken_branch1=1, address = request addr); stay RUN.
  - Request with advance=0: latch addr and pend_exc; go to PEND.
  - halt with no request: go to HALT.
- PEND:
  - exc_valid with pend_exc=0: replace the latched addr with EXC_VECTOR and set pend_exc.
  - A branch never replaces a pending redirect. An older pending redirect wins, and a younger branch is ignored.
  - Issue: taken_branch1=advance, address = pend_addr, or EXC_VECTOR if replaced this same cycle. advance=1 goes to RUN.
  - halt is ignored in PEND.
- HALT:
  - no_new_fetch=1, taken_branch1=0.
  - resume goes to RUN.
  - exc_valid latches EXC_VECTOR and goes to PEND; exception beats resume.
  - Branches are ignored.
- fetchNull2 = taken_branch1 && (exception redirect || DELAY_SLOT==0).
- nextInstruction_address = 0 when taken_branch1=0.
- Counters: stall_cnt +1 when advance=0. redirect_cnt +1 when taken_branch1=1. Both saturate at all-ones.

## Timing
- Outputs are combinational from state, the pending registers and the current inputs. No registered output delay.
- Redirect latency:
  - RUN with advance=1: 0 cycles (same-cycle issue).
  - Otherwise: issue in the first cycle advance=1.
- taken_branch1 is high exactly one cycle per redirect. The fetch stage consumes it on that rising edge.
- State and counters update on the rising CLK edge.
- RESET low, including mid-PEND or mid-HALT:
  - state=RUN, pend_addr=0, pend_exc=0, counters=0, immediately.
  - Outputs taken_branch1=0, fetchNull2=0, nextInstruction_address=0.
  - FREEZE and no_new_fetch follow their equations with state=RUN.
  - A pending redirect is discarded.
- Simultaneous exc_valid and branch: the exception wins and the branch is dropped.
- Simultaneous halt and a request in RUN: the request wins and halt is ignored.

## Structure
- Shared package: state enum (RUN, PEND, HALT), EXC_VECTOR default, redirect-kind constants.
- One sub-module, sat_counter (CNT_W, inc), instantiated twice for stall_cnt and redirect_cnt.
- The FSM and pending registers stay in fetch_ctrl.

## Test plan
- Reset, IM_READY=1, br_valid=1, br_taken=1, br_target=0x100 -> same cycle taken_branch1=1, address 0x100, fetchNull2=0 (DELAY_SLOT=1); redirect_cnt=1 next cycle.
- IM_READY=0 for 3 cycles, branch to 0x200 in cycle 1 -> PEND for cycles 1-3, taken_branch1=0. IM_READY=1 in cycle 4 -> issue 0x200, back to RUN; stall_cnt=3.
- PEND holding branch 0x300 (stall_ID=1), then exc_valid -> on release, address 0x80 with fetchNull2=1. A later branch to 0x400 while pending is ignored.
- halt -> no_new_fetch=1 for 5 cycles. resume -> RUN, no_new_fetch=0. exc_valid during HALT -> PEND, then issue 0x80 once advance=1.
- stall_ID held 70000 cycles -> stall_cnt saturates at 0xFFFF. Assert RESET mid-PEND -> counters 0, state RUN, no redirect after release.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencing controller: FSM states,
// the default exception vector and the redirect-kind encoding.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      PEND = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

   localparam logic REDIR_BRANCH = 1'b0;
   localparam logic REDIR_EXC    = 1'b1;

endpackage

// File: rtl/fetch_ctrl_sat.sv
// Saturating up-counter used for the fetch performance counters.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Increment on request, sticking at all-ones once reached.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: decides advance/freeze/redirect each
// cycle and parks redirects that arrive while fetch cannot advance.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int          DELAY_SLOT = 1,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
   parameter int          CNT_W      = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             IM_READY,
   input  logic             stall_ID,
   input  logic             br_valid,
   input  logic             br_taken,
   input  logic [31:0]      br_target,
   input  logic             exc_valid,
   input  logic             halt,
   input  logic             resume,
   output logic             FREEZE,
   output logic             no_new_fetch,
   output logic             taken_branch1,
   output logic [31:0]      nextInstruction_address,
   output logic             fetchNull2,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] redirect_cnt
);

   fetch_state_t state;
   logic [31:0]  pend_addr;
   logic         pend_exc;

   logic         advance;
   logic         req_exc;
   logic         req;
   logic [31:0]  req_addr;
   logic         issue;
   logic         issue_exc;
   logic [31:0]  issue_addr;
   logic         replace;

   assign FREEZE       = !IM_READY;
   assign no_new_fetch = stall_ID || (state == HALT);
   assign advance      = !FREEZE && !no_new_fetch;

   // An exception request always outranks a taken branch in the same cycle.
   assign req_exc  = exc_valid;
   assign req      = exc_valid || (br_valid && br_taken);
   assign req_addr = exc_valid ? EXC_VECTOR : br_target;
   assign replace  = exc_valid && !pend_exc;

   always_comb begin
      issue      = 1'b0;
      issue_exc  = REDIR_BRANCH;
      issue_addr = '0;
      case (state)
         RUN: begin
            issue      = req && advance;
            issue_exc  = req_exc;
            issue_addr = req_addr;
         end
         PEND: begin
            issue      = advance;
            issue_exc  = pend_exc || replace;
            issue_addr = replace ? EXC_VECTOR : pend_addr;
         end
         default: begin
            issue = 1'b0;
         end
      endcase
   end

   // Redirects are suppressed while reset is held, even though state reads RUN.
   assign taken_branch1           = issue && RESET;
   assign nextInstruction_address = taken_branch1 ? issue_addr : 32'h0;
   assign fetchNull2              = taken_branch1 && (issue_exc || (DELAY_SLOT == 0));

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= RUN;
         pend_addr <= '0;
         pend_exc  <= REDIR_BRANCH;
      end else begin
         case (state)
            RUN: begin
               if (req && !advance) begin
                  pend_addr <= req_addr;
                  pend_exc  <= req_exc;
                  state     <= PEND;
               end else if (!req && halt) begin
                  state <= HALT;
               end
            end
            PEND: begin
               if (advance) begin
                  pend_addr <= '0;
                  pend_exc  <= REDIR_BRANCH;
                  state     <= RUN;
               end else if (replace) begin
                  pend_addr <= EXC_VECTOR;
                  pend_exc  <= REDIR_EXC;
               end
            end
            HALT: begin
               if (exc_valid) begin
                  pend_addr <= EXC_VECTOR;
                  pend_exc  <= REDIR_EXC;
                  state     <= PEND;
               end else if (resume) begin
                  state <= RUN;
               end
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .inc   (!advance),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .inc   (taken_branch1),
      .count (redirect_cnt)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with hand-computed expectations.
module tb_fetch_ctrl;

   logic        CLK;
   logic        RESET;
   logic        IM_READY;
   logic        stall_ID;
   logic        br_valid;
   logic        br_taken;
   logic [31:0] br_target;
   logic        exc_valid;
   logic        halt;
   logic        resume;
   logic        FREEZE;
   logic        no_new_fetch;
   logic        taken_branch1;
   logic [31:0] nextInstruction_address;
   logic        fetchNull2;
   logic [15:0] stall_cnt;
   logic [15:0] redirect_cnt;

   int testsRun;
   int testsFailed;

   fetch_ctrl dut (
      .CLK                     (CLK),
      .RESET                   (RESET),
      .IM_READY                (IM_READY),
      .stall_ID                (stall_ID),
      .br_valid                (br_valid),
      .br_taken                (br_taken),
      .br_target               (br_target),
      .exc_valid               (exc_valid),
      .halt                    (halt),
      .resume                  (resume),
      .FREEZE                  (FREEZE),
      .no_new_fetch            (no_new_fetch),
      .taken_branch1           (taken_branch1),
      .nextInstruction_address (nextInstruction_address),
      .fetchNull2              (fetchNull2),
      .stall_cnt               (stall_cnt),
      .redirect_cnt            (redirect_cnt)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Inputs change on the falling edge; combinational outputs are then sampled 1ns later.
   task automatic applyStimulus(input logic im, input logic stl, input logic bv, input logic bt,
                                input logic [31:0] tgt, input logic exc, input logic hlt, input logic rsm);
      @(negedge CLK);
      IM_READY  = im;
      stall_ID  = stl;
      br_valid  = bv;
      br_taken  = bt;
      br_target = tgt;
      exc_valid = exc;
      halt      = hlt;
      resume    = rsm;
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      RESET     = 1'b0;
      IM_READY  = 1'b1;
      stall_ID  = 1'b0;
      br_valid  = 1'b1;
      br_taken  = 1'b1;
      br_target = 32'h0000_0100;
      exc_valid = 1'b0;
      halt      = 1'b0;
      resume    = 1'b0;

      // Reset with a live branch request: no redirect may escape.
      @(posedge CLK);
      #2;
      checkOutput("rst_taken", {31'b0, taken_branch1}, 32'h0);
      checkOutput("rst_addr", nextInstruction_address, 32'h0);
      checkOutput("rst_null", {31'b0, fetchNull2}, 32'h0);
      checkOutput("rst_freeze", {31'b0, FREEZE}, 32'h0);
      checkOutput("rst_nnf", {31'b0, no_new_fetch}, 32'h0);
      checkOutput("rst_stall_cnt", {16'b0, stall_cnt}, 32'h0);
      checkOutput("rst_redir_cnt", {16'b0, redirect_cnt}, 32'h0);

      @(negedge CLK);
      RESET    = 1'b1;
      br_valid = 1'b0;
      br_taken = 1'b0;

      // Same-cycle branch issue from RUN.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
      checkOutput("br_taken", {31'b0, taken_branch1}, 32'h1);
      checkOutput("br_addr", nextInstruction_address, 32'h0000_0100);
      checkOutput("br_null", {31'b0, fetchNull2}, 32'h0);
      idle();
      checkOutput("br_redir_cnt", {16'b0, redirect_cnt}, 32'd1);
      checkOutput("br_idle_taken", {31'b0, taken_branch1}, 32'h0);

      // Memory not ready: redirect parks until IM_READY returns.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
      checkOutput("frz_freeze", {31'b0, FREEZE}, 32'h1);
      checkOutput("frz_taken1", {31'b0, taken_branch1}, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("frz_taken2", {31'b0, taken_branch1}, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("frz_taken3", {31'b0, taken_branch1}, 32'h0);
      idle();
      checkOutput("frz_issue", {31'b0, taken_branch1}, 32'h1);
      checkOutput("frz_addr", nextInstruction_address, 32'h0000_0200);
      checkOutput("frz_null", {31'b0, fetchNull2}, 32'h0);
      idle();
      checkOutput("frz_stall_cnt", {16'b0, stall_cnt}, 32'd3);
      checkOutput("frz_redir_cnt", {16'b0, redirect_cnt}, 32'd2);
      checkOutput("frz_back_run", {31'b0, taken_branch1}, 32'h0);

      // Pending branch replaced by an exception; a younger branch is ignored.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0);
      checkOutput("pend_nnf", {31'b0, no_new_fetch}, 32'h1);
      checkOutput("pend_taken1", {31'b0, taken_branch1}, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("pend_taken2", {31'b0, taken_branch1}, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b0, 1'b0);
      checkOutput("pend_taken3", {31'b0, taken_branch1}, 32'h0);
      idle();
      checkOutput("pend_issue", {31'b0, taken_branch1}, 32'h1);
      checkOutput("pend_addr", nextInstruction_address, 32'h0000_0080);
      checkOutput("pend_null", {31'b0, fetchNull2}, 32'h1);
      idle();
      checkOutput("pend_no_400", {31'b0, taken_branch1}, 32'h0);
      checkOutput("pend_addr_zero", nextInstruction_address, 32'h0);
      checkOutput("pend_stall_cnt", {16'b0, stall_cnt}, 32'd6);
      checkOutput("pend_redir_cnt", {16'b0, redirect_cnt}, 32'd3);

      // Simultaneous exception and branch in RUN: exception wins.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0500, 1'b1, 1'b0, 1'b0);
      checkOutput("both_addr", nextInstruction_address, 32'h0000_0080);
      checkOutput("both_null", {31'b0, fetchNull2}, 32'h1);

      // Simultaneous halt and branch in RUN: branch wins, no halt.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0600, 1'b0, 1'b1, 1'b0);
      checkOutput("hreq_addr", nextInstruction_address, 32'h0000_0600);
      idle();
      checkOutput("hreq_nnf", {31'b0, no_new_fetch}, 32'h0);

      // Halt for five cycles, a branch inside is ignored, then resume.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("halt_entry_nnf", {31'b0, no_new_fetch}, 32'h0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, (i == 2), (i == 2), 32'h0000_0700, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("halt_nnf%0d", i), {31'b0, no_new_fetch}, 32'h1);
         checkOutput($sformatf("halt_taken%0d", i), {31'b0, taken_branch1}, 32'h0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      checkOutput("resume_nnf", {31'b0, no_new_fetch}, 32'h1);
      idle();
      checkOutput("resume_run_nnf", {31'b0, no_new_fetch}, 32'h0);
      checkOutput("resume_run_taken", {31'b0, taken_branch1}, 32'h0);

      // Exception during HALT beats resume and issues once advance returns.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      checkOutput("hexc_taken", {31'b0, taken_branch1}, 32'h0);
      idle();
      checkOutput("hexc_nnf", {31'b0, no_new_fetch}, 32'h0);
      checkOutput("hexc_issue", {31'b0, taken_branch1}, 32'h1);
      checkOutput("hexc_addr", nextInstruction_address, 32'h0000_0080);
      checkOutput("hexc_null", {31'b0, fetchNull2}, 32'h1);
      idle();
      checkOutput("hexc_stall_cnt", {16'b0, stall_cnt}, 32'd13);
      checkOutput("hexc_redir_cnt", {16'b0, redirect_cnt}, 32'd6);

      // Long decode stall with a parked branch: stall counter saturates.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0800, 1'b0, 1'b0, 1'b0);
      br_valid = 1'b0;
      br_taken = 1'b0;
      repeat (70000) @(posedge CLK);
      @(negedge CLK);
      #1;
      checkOutput("sat_stall_cnt", {16'b0, stall_cnt}, 32'h0000_FFFF);
      checkOutput("sat_redir_cnt", {16'b0, redirect_cnt}, 32'd6);
      checkOutput("sat_taken", {31'b0, taken_branch1}, 32'h0);

      // Reset mid-PEND discards the parked redirect.
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      checkOutput("mrst_stall_cnt", {16'b0, stall_cnt}, 32'h0);
      checkOutput("mrst_redir_cnt", {16'b0, redirect_cnt}, 32'h0);
      checkOutput("mrst_nnf", {31'b0, no_new_fetch}, 32'h1);
      checkOutput("mrst_taken", {31'b0, taken_branch1}, 32'h0);
      @(negedge CLK);
      RESET = 1'b1;
      idle();
      checkOutput("mrst_no_redirect", {31'b0, taken_branch1}, 32'h0);
      checkOutput("mrst_addr", nextInstruction_address, 32'h0);
      checkOutput("mrst_nnf_run", {31'b0, no_new_fetch}, 32'h0);
      idle();
      checkOutput("mrst_redir_after", {16'b0, redirect_cnt}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
